ub_arbiter: RTL

UB_ARBITER -- requirements
Module: ub_arbiter

---
 rtl/ub_arbiter.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/ub_arbiter.sv
// -----------------------------------------------------------------------------
// ub_arbiter
//
// Arbitrates four requesters onto the unified buffer's single write port and
// single read port.
//   Write port : accumulator writeback vs. host write. Bursts are limited to
//                MAX_BURST transfers. The burst then hands over to the other
//                writer, or returns to idle.
//   Read port  : activation-staging reads have priority over host readback.
//                After STARVE_LIMIT consecutive activation grants while the
//                host is waiting, the next read slot goes to the host.
//
// Configuration macro:
//   UB_ARB_RAW_HAZARD_EN - when defined, a read whose address equals the
//                          write address granted in the same cycle is held
//                          off for that cycle, so it returns the new data.
//                          When undefined, reads ignore writes entirely.
//
// Ports:
//   clk_i, rst_i                      clock, synchronous active-low reset
//   acc_wr_req_i/_addr_i/_data_i      accumulator write request
//   host_wr_req_i/_addr_i/_data_i     host write request
//   act_rd_req_i/_addr_i              activation read request
//   host_rd_req_i/_addr_i             host read request
//   *_gnt_o                           request accepted this cycle
//   ub_write_o/ub_addr_wr_o/ub_data_o registered buffer write port
//   ub_read_o/ub_addr_rd_o            registered buffer read port
//   host_rd_valid_o                   buffer output holds host read data
//   busy_o                            any request, port activity or burst
//
// Vector data is flattened: lane i occupies bits [i*DATA_W +: DATA_W].
// -----------------------------------------------------------------------------
module ub_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int LANES        = 32,
  parameter int DATA_W       = 16,
  parameter int MAX_BURST    = 16,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      acc_wr_req_i,
  input  logic [ADDR_W-1:0]         acc_wr_addr_i,
  input  logic [LANES*DATA_W-1:0]   acc_wr_data_i,
  input  logic                      host_wr_req_i,
  input  logic [ADDR_W-1:0]         host_wr_addr_i,
  input  logic [LANES*DATA_W-1:0]   host_wr_data_i,
  input  logic                      act_rd_req_i,
  input  logic [ADDR_W-1:0]         act_rd_addr_i,
  input  logic                      host_rd_req_i,
  input  logic [ADDR_W-1:0]         host_rd_addr_i,
  output logic                      acc_wr_gnt_o,
  output logic                      host_wr_gnt_o,
  output logic                      act_rd_gnt_o,
  output logic                      host_rd_gnt_o,
  output logic                      ub_write_o,
  output logic [ADDR_W-1:0]         ub_addr_wr_o,
  output logic [LANES*DATA_W-1:0]   ub_data_o,
  output logic                      ub_read_o,
  output logic [ADDR_W-1:0]         ub_addr_rd_o,
  output logic                      host_rd_valid_o,
  output logic                      busy_o
);

  localparam int VEC_W  = LANES * DATA_W;
  localparam int BCNT_W = $clog2(MAX_BURST + 1);
  localparam int SCNT_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [BCNT_W-1:0] BURST_MAX  = BCNT_W'(MAX_BURST);
  localparam logic [BCNT_W-1:0] BURST_ONE  = BCNT_W'(1);
  localparam logic [SCNT_W-1:0] STARVE_MAX = SCNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ACC  = 2'd1,
    W_HOST = 2'd2
  } wstate_e;

  // Write-port state
  wstate_e             r_wstate;
  logic [BCNT_W-1:0]   r_bcnt;
  logic                r_last_host;

  // Read-port state
  logic [SCNT_W-1:0]   r_scnt;

  // Registered buffer ports
  logic                r_ub_write_p1;
  logic [ADDR_W-1:0]   r_ub_addr_wr_p1;
  logic [VEC_W-1:0]    r_ub_data_p1;
  logic                r_ub_read_p1;
  logic [ADDR_W-1:0]   r_ub_addr_rd_p1;
  logic                r_host_rd_p1;
  logic                r_host_rd_valid_p2;

  // Arbitration wires
  logic                w_sel_acc;
  logic                w_sel_host;
  logic                w_wr_gnt;
  logic [ADDR_W-1:0]   w_wr_addr;
  logic [VEC_W-1:0]    w_wr_data;
  logic                w_force_host;
  logic                w_host_pick;
  logic                w_act_pick;
  logic [ADDR_W-1:0]   w_rd_addr;
  logic                w_raw_hit;
  logic                w_act_rd_gnt;
  logic                w_host_rd_gnt;
  logic                w_rd_gnt;

  // ---------------------------------------------------------------------------
  // Write arbitration (combinational, stage p0)
  //
  // A writer is served in the same cycle its state is entered: from W_IDLE the
  // chosen writer is granted immediately, and when a burst ends the other
  // writer is granted in the very next cycle without a bubble. The burst
  // counter therefore counts transfers made in the current state, including
  // the one on the edge that entered it.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_sel_acc  = 1'b0;
    w_sel_host = 1'b0;
    if (rst_i) begin
      case (r_wstate)
        W_IDLE: begin
          if (acc_wr_req_i && host_wr_req_i) begin
            // Alternate on contention; r_last_host resets high so acc goes first.
            if (r_last_host) w_sel_acc  = 1'b1;
            else             w_sel_host = 1'b1;
          end else if (acc_wr_req_i) begin
            w_sel_acc = 1'b1;
          end else if (host_wr_req_i) begin
            w_sel_host = 1'b1;
          end
        end
        W_ACC: begin
          if (acc_wr_req_i && (r_bcnt < BURST_MAX)) w_sel_acc  = 1'b1;
          else if (host_wr_req_i)                   w_sel_host = 1'b1;
        end
        W_HOST: begin
          if (host_wr_req_i && (r_bcnt < BURST_MAX)) w_sel_host = 1'b1;
          else if (acc_wr_req_i)                     w_sel_acc  = 1'b1;
        end
        default: begin
          w_sel_acc  = 1'b0;
          w_sel_host = 1'b0;
        end
      endcase
    end
  end

  assign w_wr_gnt  = w_sel_acc | w_sel_host;
  assign w_wr_addr = w_sel_acc ? acc_wr_addr_i : host_wr_addr_i;
  assign w_wr_data = w_sel_acc ? acc_wr_data_i : host_wr_data_i;

  // ---------------------------------------------------------------------------
  // Read arbitration (combinational, stage p0)
  // ---------------------------------------------------------------------------
  assign w_force_host = (r_scnt >= STARVE_MAX);
  assign w_host_pick  = host_rd_req_i && (!act_rd_req_i || w_force_host);
  assign w_act_pick   = act_rd_req_i && !w_host_pick;
  assign w_rd_addr    = w_host_pick ? host_rd_addr_i : act_rd_addr_i;

`ifdef UB_ARB_RAW_HAZARD_EN
  // Hold the read off for one cycle so it observes the data being written.
  assign w_raw_hit = w_wr_gnt && (w_rd_addr == w_wr_addr);
`else
  assign w_raw_hit = 1'b0;
`endif

  assign w_act_rd_gnt  = rst_i && w_act_pick  && !w_raw_hit;
  assign w_host_rd_gnt = rst_i && w_host_pick && !w_raw_hit;
  assign w_rd_gnt      = w_act_rd_gnt | w_host_rd_gnt;

  assign acc_wr_gnt_o  = w_sel_acc;
  assign host_wr_gnt_o = w_sel_host;
  assign act_rd_gnt_o  = w_act_rd_gnt;
  assign host_rd_gnt_o = w_host_rd_gnt;

  // ---------------------------------------------------------------------------
  // Write FSM and burst counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_wstate    <= W_IDLE;
      r_bcnt      <= '0;
      r_last_host <= 1'b1;
    end else if (w_sel_acc) begin
      r_last_host <= 1'b0;
      if (r_wstate == W_ACC) begin
        r_bcnt <= r_bcnt + 1'b1;
      end else begin
        r_wstate <= W_ACC;
        r_bcnt   <= BURST_ONE;
      end
    end else if (w_sel_host) begin
      r_last_host <= 1'b1;
      if (r_wstate == W_HOST) begin
        r_bcnt <= r_bcnt + 1'b1;
      end else begin
        r_wstate <= W_HOST;
        r_bcnt   <= BURST_ONE;
      end
    end else begin
      r_wstate <= W_IDLE;
      r_bcnt   <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Starvation counter: counts activation grants the waiting host has lost.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_scnt <= '0;
    end else if (w_host_rd_gnt || !host_rd_req_i) begin
      r_scnt <= '0;
    end else if (w_act_rd_gnt && (r_scnt != STARVE_MAX)) begin
      r_scnt <= r_scnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p1: buffer port registers (grant in cycle N drives the port in N+1).
  // Address and data are cleared by reset as well, so every output is zero
  // after a reset edge. They hold their last value between transfers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_ub_write_p1   <= 1'b0;
      r_ub_addr_wr_p1 <= '0;
      r_ub_data_p1    <= '0;
      r_ub_read_p1    <= 1'b0;
      r_ub_addr_rd_p1 <= '0;
      r_host_rd_p1    <= 1'b0;
    end else begin
      r_ub_write_p1 <= w_wr_gnt;
      r_ub_read_p1  <= w_rd_gnt;
      r_host_rd_p1  <= w_host_rd_gnt;
      if (w_wr_gnt) begin
        r_ub_addr_wr_p1 <= w_wr_addr;
        r_ub_data_p1    <= w_wr_data;
      end
      if (w_rd_gnt) begin
        r_ub_addr_rd_p1 <= w_rd_addr;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p2: buffer read data is available, flag host readback.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_host_rd_valid_p2 <= 1'b0;
    end else begin
      r_host_rd_valid_p2 <= r_host_rd_p1;
    end
  end

  assign ub_write_o      = r_ub_write_p1;
  assign ub_addr_wr_o    = r_ub_addr_wr_p1;
  assign ub_data_o       = r_ub_data_p1;
  assign ub_read_o       = r_ub_read_p1;
  assign ub_addr_rd_o    = r_ub_addr_rd_p1;
  assign host_rd_valid_o = r_host_rd_valid_p2;

  assign busy_o = acc_wr_req_i | host_wr_req_i | act_rd_req_i | host_rd_req_i |
                  r_ub_write_p1 | r_ub_read_p1 | (r_wstate != W_IDLE);

endmodule
